pwm_capture: RTL and testbench

Measures an incoming PWM waveform of the kind our ramp PWM generator produces. It reports high time and period in clock cycles once per PWM period, and flags a stuck line. It sits at the receiving end of a PWM link, after the pin and before any duty-cycle consumer or loop-back checker. It is one-clock and fully synchronous apart from the input synchronizer and the asynchronous reset.

---
 rtl/pwm_capture.sv | 142 ++++++++++++++
 tb/tb_pwm_capture.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time per PWM period and flags a stuck line.
// Optional glitch filter on the synchronized input is enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ARM, RUN, STUCK} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_per;
  logic [CNT_W-1:0]       cnt_hi;
  state_t                 state;
  state_t                 state_nxt;
  logic                   capture;
  logic                   enter_stuck;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] filt_cnt;
  logic          filt_lvl;

  // Counts consecutive cycles the synchronized input disagrees with filt_lvl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      filt_lvl <= sync[SYNC_STAGES-1];
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync[SYNC_STAGES-1];
`endif

  assign rise = lvl & ~lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d   <= 1'b0;
      cnt_per <= '0;
      cnt_hi  <= '0;
    end else begin
      lvl_d <= lvl;
      if (rise)               cnt_per <= CNT_W'(1);
      else if (cnt_per != TMO) cnt_per <= cnt_per + 1'b1;
      if (rise)                      cnt_hi <= CNT_W'(1);
      else if (lvl && cnt_hi != TMO) cnt_hi <= cnt_hi + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    enter_stuck = 1'b0;
    case (state)
      ARM: begin
        if (rise) begin
          state_nxt = RUN;
        end else if (cnt_per == TMO) begin
          state_nxt   = STUCK;
          enter_stuck = 1'b1;
        end
      end
      RUN: begin
        if (rise) begin
          capture = 1'b1;
        end else if (cnt_per == TMO) begin
          state_nxt   = STUCK;
          enter_stuck = 1'b1;
        end
      end
      STUCK: begin
        if (rise) state_nxt = ARM;
      end
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= capture | enter_stuck;
      if (capture) begin
        period    <= cnt_per;
        high_time <= cnt_hi;
      end else if (enter_stuck) begin
        period    <= '0;
        high_time <= lvl ? TMO : '0;
      end
      if (enter_stuck) begin
        stuck       <= 1'b1;
        stuck_level <= lvl;
      end else if (state == STUCK) begin
        // The rise that releases the line also clears the level report.
        stuck       <= ~rise;
        stuck_level <= rise ? 1'b0 : lvl;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (default build): drives PWM segments and compares each valid
// against measurements derived from the driven waveform.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TMO   = 5000;
  localparam int SS    = 2;
  localparam int LAT   = SS + 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  pwm_capture #(
    .CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(SS), .FILT_LEN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .period(period),
    .high_time(high_time), .valid(valid), .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int h;
    bit st;
    bit lv;
    int due;
    int tol;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Waveform-level model: what matters is where rises fall and how long the line sits.
  bit cur, open, stuck_m, from_reset;
  int age, win_p, win_h, last_rise_c, rel_c;

  task automatic drive_level(input bit v, input int n);
    if (v && !cur) begin
      if (stuck_m)    stuck_m = 1'b0;
      else if (!open) open = 1'b1;
      else            q.push_back(exp_t'{win_p, win_h, 1'b0, 1'b0, cyc + LAT, 0});
      last_rise_c = cyc;
      age = 0; win_p = 0; win_h = 0; from_reset = 1'b0;
    end
    if (!stuck_m && age + n > TMO) begin
      stuck_m = 1'b1;
      open = 1'b0;
      if (from_reset) q.push_back(exp_t'{0, v ? TMO : 0, 1'b1, v, rel_c + TMO + 1, 1});
      else            q.push_back(exp_t'{0, v ? TMO : 0, 1'b1, v, last_rise_c + LAT + TMO, 0});
    end
    age += n;
    win_p += n;
    if (v) win_h += n;
    cur = v;
    repeat (n) begin
      pwm_in = v;
      @(negedge clk);
    end
  endtask

  task automatic drive_period(input int p, input int h);
    if (h > 0) drive_level(1'b1, h);
    drive_level(1'b0, p - h);
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_stuck_level", stuck_level, 0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    cur = 1'b0; open = 1'b0; stuck_m = 1'b0; from_reset = 1'b1;
    age = 0; win_p = 0; win_h = 0; rel_c = cyc;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("period", period, e.p);
        check("high_time", high_time, e.h);
        check("stuck", stuck, e.st);
        if (e.st) check("stuck_level", stuck_level, e.lv);
        if (e.tol == 0) check("valid_time", cyc, e.due);
        else check("stuck_time_window", (cyc >= e.due - e.tol) && (cyc <= e.due), 1);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    @(negedge clk);
    apply_reset(3);

    // Line held low from reset.
    drive_level(1'b0, TMO + 300);
    check("sl_stuck", stuck, 1);
    check("sl_level", stuck_level, 0);
    check("sl_period", period, 0);
    check("sl_high_time", high_time, 0);

    // Line held high, then low while still stuck, then PWM resumes.
    drive_level(1'b1, TMO + 300);
    check("sh_stuck", stuck, 1);
    check("sh_level", stuck_level, 1);
    check("sh_high_time", high_time, TMO);
    drive_level(1'b0, 50);
    check("sh_still_stuck", stuck, 1);
    check("sh_level_tracks", stuck_level, 0);
    drive_level(1'b1, 100);
    check("recover_clear", stuck, 0);
    drive_level(1'b0, 200);
    repeat (3) drive_period(300, 100);

    // Reset in the middle of a high phase.
    drive_level(1'b1, 200);
    check("queue_before_reset", q.size(), 0);
    apply_reset(5);

    // Steady PWM, then a duty ramp.
    repeat (5) drive_period(1024, 256);
    for (int h = 0; h < 1000; h += 111) drive_period(1000, h);

    // Narrow extremes and a two-cycle low glitch.
    repeat (3) drive_period(2, 1);
    repeat (2) drive_period(50, 49);
    drive_level(1'b1, 50);
    drive_level(1'b0, 2);
    drive_level(1'b1, 48);
    drive_level(1'b0, 200);

    repeat (12) begin
      int p, h;
      p = int'($urandom_range(600, 2));
      h = int'($urandom_range(p - 1, 1));
      drive_period(p, h);
    end

    // A period of exactly TIMEOUT must still measure, not trip stuck.
    drive_period(TMO, 1234);
    drive_period(100, 40);
    drive_level(1'b1, 5);
    drive_level(1'b0, 20);
    check("no_stuck_at_end", stuck, 0);

    w = 0;
    while (q.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
